uart_block_assembler: RTL and testbench

- Sits directly downstream of the UART receiver. Consumes its byte stream (single-byte valid strobe plus 8-bit data).
- Packs 16 consecutive bytes into one 128-bit block for the AES-128 core.
- Presents the block on a valid/ready handshake and holds it stable until the core accepts it.
- Flags bytes that arrive while a block is still pending.

---
 rtl/uart_block_assembler.sv | 136 +++++++++++++
 tb/tb_uart_block_assembler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_block_assembler.sv
// Packs UART receiver bytes into AES-sized blocks on a valid/ready port.
// Optional idle-timeout discard of partial blocks: UART_BLOCK_ASSEMBLER_TIMEOUT_EN.
module uart_block_assembler #(
  parameter int BLOCK_BYTES  = 16,
  parameter int TIMEOUT_CLKS = 34720
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     Rx_DV_in,
  input  logic [7:0]               Rx_Byte_in,
  input  logic                     Block_Ready_in,
  output logic                     Block_Valid_out,
  output logic [8*BLOCK_BYTES-1:0] Block_out,
  output logic [4:0]               Fill_Level_out,
  output logic                     Overrun_out,
  output logic                     Timeout_out
);

  localparam int BW = 8 * BLOCK_BYTES;
  localparam logic [4:0] LAST = 5'(BLOCK_BYTES - 1);
  localparam logic [4:0] FULL = 5'(BLOCK_BYTES);

  typedef enum logic {S_COLLECT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic            dv_q;
  logic [BW-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [4:0]      fill_q, fill_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            strobe, handshake, expire;
  logic [BW-1:0]   shifted;

  // A held-high strobe is a single byte: act only on its rising edge.
  assign strobe    = Rx_DV_in & ~dv_q;
  assign handshake = valid_q & Block_Ready_in;
  assign shifted   = {shreg_q[BW-9:0], Rx_Byte_in};

`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          tmo_q;

  assign expire = (state_q == S_COLLECT) && (fill_q != '0) && (cnt_q == TMAX);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_HOLD) begin
      if (handshake) cnt_d = '0;
    end else if (strobe || fill_q == '0 || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= expire & ~strobe;
    end
  end

  assign Timeout_out = tmo_q;
`else
  assign expire      = 1'b0;
  assign Timeout_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    blk_d   = blk_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    unique case (state_q)
      S_COLLECT: begin
        if (strobe) begin
          shreg_d = shifted;
          fill_d  = fill_q + 5'd1;
          if (fill_q == LAST) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
            blk_d   = shifted;
            fill_d  = FULL;
          end
        end else if (expire) begin
          fill_d = '0;
        end
      end
      S_HOLD: begin
        if (handshake) begin
          state_d = S_COLLECT;
          valid_d = 1'b0;
          fill_d  = strobe ? 5'd1 : 5'd0;
          if (strobe) shreg_d = shifted;
        end else if (strobe) begin
          ovr_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_COLLECT;
      dv_q    <= 1'b0;
      shreg_q <= '0;
      blk_q   <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= Rx_DV_in;
      shreg_q <= shreg_d;
      blk_q   <= blk_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Block_Valid_out = valid_q;
  assign Block_out       = blk_q;
  assign Fill_Level_out  = fill_q;
  assign Overrun_out     = ovr_q;

endmodule

// File: tb/tb_uart_block_assembler.sv
// Directed bench for uart_block_assembler with a block scoreboard.
// Timeout checks follow UART_BLOCK_ASSEMBLER_TIMEOUT_EN.
module tb_uart_block_assembler;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         Rx_DV_in;
  logic [7:0]   Rx_Byte_in;
  logic         Block_Ready_in;
  logic         Block_Valid_out;
  logic [127:0] Block_out;
  logic [4:0]   Fill_Level_out;
  logic         Overrun_out;
  logic         Timeout_out;

  int n_vec = 0;
  int n_err = 0;
  int ovr_pulses = 0;
  int tmo_pulses = 0;

  logic [127:0] exp_q[$];
  logic [127:0] mblk = '0;
  int           mcnt = 0;

  always #5 CLK = ~CLK;

  uart_block_assembler #(.BLOCK_BYTES(16), .TIMEOUT_CLKS(100)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .Rx_DV_in       (Rx_DV_in),
    .Rx_Byte_in     (Rx_Byte_in),
    .Block_Ready_in (Block_Ready_in),
    .Block_Valid_out(Block_Valid_out),
    .Block_out      (Block_out),
    .Fill_Level_out (Fill_Level_out),
    .Overrun_out    (Overrun_out),
    .Timeout_out    (Timeout_out)
  );

  always @(negedge CLK) begin
    if (Overrun_out === 1'b1) ovr_pulses++;
    if (Timeout_out === 1'b1) tmo_pulses++;
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    Rx_DV_in   = 1'b1;
    Rx_Byte_in = b;
    @(negedge CLK);
    Rx_DV_in   = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    mblk = {mblk[119:0], b};
    mcnt++;
    if (mcnt == 16) begin
      exp_q.push_back(mblk);
      mcnt = 0;
    end
  endtask

  task automatic send_model(input logic [7:0] b);
    send_byte(b);
    model_byte(b);
  endtask

  task automatic take_block(input string tag);
    check({tag, "_valid"}, 128'(Block_Valid_out), 128'd1);
    check({tag, "_fill"}, 128'(Fill_Level_out), 128'd16);
    n_vec++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected a block", tag);
    end
    if (exp_q.size() != 0) check(tag, Block_out, exp_q.pop_front());
  endtask

  task automatic handshake();
    @(negedge CLK);
    Block_Ready_in = 1'b1;
    @(negedge CLK);
    Block_Ready_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    mblk = '0;
    mcnt = 0;
  endtask

  initial begin
    logic [127:0] held;
    RST_N          = 1'b0;
    Rx_DV_in       = 1'b0;
    Rx_Byte_in     = 8'h00;
    Block_Ready_in = 1'b0;

    // reset values
    repeat (3) @(negedge CLK);
    check("rst_valid", 128'(Block_Valid_out), 128'd0);
    check("rst_block", Block_out, 128'd0);
    check("rst_fill", 128'(Fill_Level_out), 128'd0);
    check("rst_ovr", 128'(Overrun_out), 128'd0);
    check("rst_tmo", 128'(Timeout_out), 128'd0);
    RST_N = 1'b1;

    // first block, ready low, then hold for 50 cycles
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("fill15", 128'(Fill_Level_out), 128'd15);
      send_model(8'(i));
    end
    check("blk0_lit", Block_out, 128'h000102030405060708090A0B0C0D0E0F);
    take_block("blk0");
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      check("hold_valid", 128'(Block_Valid_out), 128'd1);
      check("hold_block", Block_out, 128'h000102030405060708090A0B0C0D0E0F);
    end

    handshake();
    check("hs_valid", 128'(Block_Valid_out), 128'd0);
    check("hs_fill", 128'(Fill_Level_out), 128'd0);

    // descending block
    for (int i = 0; i < 16; i++) send_model(8'(8'hFF - i));
    check("blk1_lit", Block_out, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    take_block("blk1");

    // overrun: strobe with ready low
    held = Block_out;
    @(negedge CLK);
    Rx_DV_in   = 1'b1;
    Rx_Byte_in = 8'hAA;
    @(negedge CLK);
    Rx_DV_in   = 1'b0;
    check("ovr_pulse", 128'(Overrun_out), 128'd1);
    @(negedge CLK);
    check("ovr_clear", 128'(Overrun_out), 128'd0);
    check("ovr_block", Block_out, held);
    check("ovr_fill", 128'(Fill_Level_out), 128'd16);
    check("ovr_valid", 128'(Block_Valid_out), 128'd1);

    // strobe coincident with handshake is byte 0 of next block
    @(negedge CLK);
    Rx_DV_in       = 1'b1;
    Rx_Byte_in     = 8'hAA;
    Block_Ready_in = 1'b1;
    @(negedge CLK);
    Rx_DV_in       = 1'b0;
    Block_Ready_in = 1'b0;
    model_byte(8'hAA);
    check("co_valid", 128'(Block_Valid_out), 128'd0);
    check("co_fill", 128'(Fill_Level_out), 128'd1);
    check("co_ovr", 128'(Overrun_out), 128'd0);
    for (int i = 0; i < 15; i++) send_model(8'(8'h10 + i));
    check("blk2_lit", Block_out, 128'hAA101112131415161718191A1B1C1D1E);
    take_block("blk2");
    handshake();

    // DV held high for 5 cycles counts once
    @(negedge CLK);
    Rx_DV_in   = 1'b1;
    Rx_Byte_in = 8'h5A;
    repeat (5) @(negedge CLK);
    Rx_DV_in = 1'b0;
    model_byte(8'h5A);
    check("dvhold_fill", 128'(Fill_Level_out), 128'd1);
    for (int i = 0; i < 15; i++) send_model(8'(8'hC0 + i));
    take_block("blk3");
    handshake();

    // asynchronous reset mid-block
    for (int i = 0; i < 7; i++) send_byte(8'(8'h70 + i));
    check("pre_rst_fill", 128'(Fill_Level_out), 128'd7);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("arst_fill", 128'(Fill_Level_out), 128'd0);
    check("arst_valid", 128'(Block_Valid_out), 128'd0);
    check("arst_block", Block_out, 128'd0);
    check("arst_ovr", 128'(Overrun_out), 128'd0);
    check("arst_tmo", 128'(Timeout_out), 128'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    mblk  = '0;
    mcnt  = 0;
    for (int i = 0; i < 16; i++) send_model(8'($urandom_range(255)));
    take_block("blk4");
    handshake();

    // idle after a partial block
    tmo_pulses = 0;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i));
    repeat (110) @(negedge CLK);
`ifdef UART_BLOCK_ASSEMBLER_TIMEOUT_EN
    check("tmo_pulses", 128'(tmo_pulses), 128'd1);
    check("tmo_fill", 128'(Fill_Level_out), 128'd0);
`else
    check("tmo_pulses", 128'(tmo_pulses), 128'd0);
    check("tmo_fill", 128'(Fill_Level_out), 128'd5);
    do_reset();
`endif

    // slow bytes with 90-cycle gaps never time out
    tmo_pulses = 0;
    for (int i = 0; i < 16; i++) begin
      send_model(8'(8'h80 + i));
      if (i != 15) repeat (90) @(negedge CLK);
    end
    check("gap_tmo", 128'(tmo_pulses), 128'd0);
    take_block("blk5");
    handshake();

    check("ovr_total", 128'(ovr_pulses), 128'd1);
    check("sb_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
